// File: rtl/fetch_queue_pkg.sv
// Opcode classes and mem_ctrl encodings shared by the fetch front end.
package fetch_queue_pkg;

    localparam int CLASS_OP_LSB = 0;
    localparam int CLASS_OP_MSB = 6;

    localparam logic [6:0] CLASS_BRANCH = 7'b1100011;
    localparam logic [6:0] CLASS_JAL    = 7'b1101111;
    localparam logic [6:0] CLASS_JALR   = 7'b1100111;

    localparam logic [1:0] MEM_RW_NONE  = 2'b00;
    localparam logic [1:0] MEM_RW_READ  = 2'b01;
    localparam logic [1:0] MEM_LEN_WORD = 2'b11;

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == CLASS_BRANCH) || (op == CLASS_JAL) || (op == CLASS_JALR);
    endfunction

endpackage

// File: rtl/fetch_iq.sv
// Circular instruction queue with push/pop/flush and a combinational head port.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full; flush wins over push and pop.
module fetch_iq #(
    parameter  int W     = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head_dat,
    output logic [PW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push  = en && push && !flush;
    assign do_pop   = en && pop && !flush && (count != '0);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (en && flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push != do_pop)
                count <= do_push ? count + PW'(1) : count - PW'(1);
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word reads, queues {pc, inst}, feeds the Decoder.
// Latency: mem_done at edge N makes dec_valid high after edge N; redirect to new request >= 1 cycle.
// Backpressure: issue only while count + outstanding < IQ_DEPTH; rdy low freezes everything.
import fetch_queue_pkg::*;

module fetch_queue #(
    parameter int                ADDR_W        = 32,
    parameter int                INST_W        = 32,
    parameter int                IQ_DEPTH      = 4,
    parameter int                STALL_ON_CTRL = 1,
    parameter logic [ADDR_W-1:0] RESET_PC      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    output logic [1:0]        mem_rw_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_len,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    output logic              dec_valid,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [INST_W-1:0] dec_inst,
    input  logic              dec_ready,
    input  logic              redir_alu_valid,
    input  logic [ADDR_W-1:0] redir_alu_dest,
    input  logic              redir_br_valid,
    input  logic [ADDR_W-1:0] redir_br_dest,
    input  logic              redir_dec_valid,
    input  logic [ADDR_W-1:0] redir_dec_dest
);

    localparam int PW = $clog2(IQ_DEPTH) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD, ST_DRAIN} state_t;

    state_t                     state;
    logic [ADDR_W-1:0]          fetch_pc;
    logic [ADDR_W-1:0]          req_pc;
    logic [PW-1:0]              count;
    logic [ADDR_W+INST_W-1:0]   head;
    logic                       redir;
    logic [ADDR_W-1:0]          redir_dest;
    logic                       pop;
    logic                       push;
    logic                       ctrl;
    logic                       slot_free;
    logic                       slot_free_after;
    logic                       issue;

    always_comb begin
        redir      = redir_alu_valid || redir_br_valid || redir_dec_valid;
        redir_dest = redir_dec_dest;
        if (redir_alu_valid)     redir_dest = redir_alu_dest;
        else if (redir_br_valid) redir_dest = redir_br_dest;
    end

    assign pop  = dec_valid && dec_ready;
    assign push = (state == ST_WAIT) && mem_done && !redir;
    assign ctrl = (STALL_ON_CTRL != 0) && is_ctrl(mem_rdata[CLASS_OP_MSB:CLASS_OP_LSB]);

    // In IDLE nothing is outstanding; in WAIT the returning word takes one slot.
    assign slot_free       = count < PW'(IQ_DEPTH);
    assign slot_free_after = ({1'b0, count} + (PW+1)'(1)) < ({1'b0, PW'(IQ_DEPTH)} + (PW+1)'(pop));

    assign issue = !redir && !mem_busy &&
                   (((state == ST_IDLE) && slot_free) ||
                    ((state == ST_WAIT) && mem_done && !ctrl && slot_free_after));

    fetch_iq #(
        .W     (ADDR_W + INST_W),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (rdy),
        .push     (push),
        .push_dat ({req_pc, mem_rdata}),
        .pop      (pop),
        .flush    (redir),
        .head_dat (head),
        .count    (count)
    );

    assign mem_len   = MEM_LEN_WORD;
    assign dec_valid = (count != '0);
    assign dec_pc    = dec_valid ? head[ADDR_W+INST_W-1:INST_W] : '0;
    assign dec_inst  = dec_valid ? head[INST_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            mem_rw_flag <= MEM_RW_NONE;
            mem_addr    <= RESET_PC;
        end else if (rdy) begin
            mem_rw_flag <= MEM_RW_NONE;
            if (issue) begin
                mem_rw_flag <= MEM_RW_READ;
                mem_addr    <= fetch_pc;
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(4);
                state       <= ST_WAIT;
            end else if (redir) begin
                // An outstanding read still has to come back and be dropped.
                fetch_pc <= redir_dest;
                state    <= (((state == ST_WAIT) || (state == ST_DRAIN)) && !mem_done)
                            ? ST_DRAIN : ST_IDLE;
            end else begin
                case (state)
                    ST_WAIT:  if (mem_done) state <= ctrl ? ST_HOLD : ST_IDLE;
                    ST_DRAIN: if (mem_done) state <= ST_IDLE;
                    default:  state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a mem_ctrl model and request/decoder scoreboards.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n, rdy;
    logic [1:0]  mem_rw_flag, mem_len;
    logic [31:0] mem_addr, mem_rdata;
    logic        mem_busy, mem_done;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_pc, dec_inst;
    logic        redir_alu_valid, redir_br_valid, redir_dec_valid;
    logic [31:0] redir_alu_dest, redir_br_dest, redir_dec_dest;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_W(32), .INST_W(32), .IQ_DEPTH(4), .STALL_ON_CTRL(1), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_done(mem_done),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_ready(dec_ready),
        .redir_alu_valid(redir_alu_valid), .redir_alu_dest(redir_alu_dest),
        .redir_br_valid(redir_br_valid), .redir_br_dest(redir_br_dest),
        .redir_dec_valid(redir_dec_valid), .redir_dec_dest(redir_dec_dest)
    );

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int r0;
    logic [31:0] ctrl_addr;
    logic [31:0] exp_req[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_inst[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // JAL at ctrl_addr, otherwise an ADDI whose upper bits encode the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == ctrl_addr) ? 32'h0000006F : {a[24:0], 7'h13};
    endfunction

    // Monitor: values at the negedge are exactly what the next posedge samples.
    initial forever begin
        @(negedge clk);
        if (rst_n && rdy && mem_rw_flag == 2'b01) begin
            req_cnt++;
            checks++;
            assert (exp_req.size() != 0) else begin
                errors++;
                $error("FAIL req_unexpected: observed request %0h, expected none", mem_addr);
            end
            if (exp_req.size() != 0) chk("req_addr", mem_addr, exp_req.pop_front());
            chk("req_len", mem_len, 2'b11);
        end
        if (rst_n && rdy && dec_valid && dec_ready) begin
            checks++;
            assert (exp_pc.size() != 0) else begin
                errors++;
                $error("FAIL dec_unexpected: observed pc %0h, expected no entry", dec_pc);
            end
            if (exp_pc.size() != 0) begin
                chk("dec_pc", dec_pc, exp_pc.pop_front());
                chk("dec_inst", dec_inst, exp_inst.pop_front());
            end
        end
    end

    // mem_ctrl model: answers a request one cycle after accepting it, holds mem_done until rdy.
    bit          take_done, new_req;
    logic [31:0] new_addr;
    initial forever begin
        @(negedge clk);
        take_done = rst_n && rdy && mem_done;
        new_req   = rst_n && rdy && (mem_rw_flag == 2'b01);
        new_addr  = mem_addr;
    end
    initial begin
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (take_done) mem_done = 1'b0;
            if (new_req) begin
                mem_done  = 1'b1;
                mem_rdata = word_at(new_addr);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_flag(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (mem_rw_flag == 2'b01 && rdy) seen = 1'b1;
        end
        chk({tag, "_seen"}, {63'b0, seen}, 64'd1);
    endtask

    task automatic expect_req(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic expect_dec(input logic [31:0] a);
        exp_pc.push_back(a);
        exp_inst.push_back(word_at(a));
    endtask

    initial begin
        bit seen;
        rst_n = 1'b1; rdy = 1'b1; dec_ready = 1'b0; mem_busy = 1'b0;
        redir_alu_valid = 1'b0; redir_br_valid = 1'b0; redir_dec_valid = 1'b0;
        redir_alu_dest = '0; redir_br_dest = '0; redir_dec_dest = '0;
        ctrl_addr = 32'h8;
        #1 rst_n = 1'b0;

        @(negedge clk);
        chk("rst_flag", mem_rw_flag, 2'b00);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_inst", dec_inst, 32'h0);

        // In-order fetch from RESET_PC; the JAL at 0x8 stops fetching.
        expect_req(32'h0); expect_req(32'h4); expect_req(32'h8);
        expect_dec(32'h0); expect_dec(32'h4); expect_dec(32'h8);
        dec_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_done) seen = 1'b1;
        end
        chk("first_done_seen", {63'b0, seen}, 64'd1);
        chk("valid_before_push", dec_valid, 1'b0);
        @(negedge clk);
        chk("valid_after_push", dec_valid, 1'b1);
        chk("first_pc", dec_pc, 32'h0);
        repeat (20) tick();
        chk("jal_req_count", req_cnt, 3);
        chk("hold_flag_quiet", mem_rw_flag, 2'b00);
        chk("p1_req_left", exp_req.size(), 0);
        chk("p1_dec_left", exp_pc.size(), 0);

        // Redirect out of HOLD with the Decoder stalled: exactly IQ_DEPTH requests.
        dec_ready = 1'b0;
        ctrl_addr = 32'hFFFF_0000;
        expect_req(32'h40); expect_req(32'h44); expect_req(32'h48); expect_req(32'h4C);
        r0 = req_cnt;
        redir_dec_valid = 1'b1; redir_dec_dest = 32'h40;
        tick();
        redir_dec_valid = 1'b0;
        repeat (25) tick();
        chk("full_req_count", req_cnt - r0, 4);
        chk("full_head_pc", dec_pc, 32'h40);
        chk("full_flag_quiet", mem_rw_flag, 2'b00);

        // One pop frees one slot for exactly one new request.
        expect_dec(32'h40);
        expect_req(32'h50);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        repeat (10) tick();
        chk("one_pop_req_count", req_cnt - r0, 5);
        chk("one_pop_head_pc", dec_pc, 32'h44);
        chk("one_pop_dec_left", exp_pc.size(), 0);

        // Branch redirect the cycle before mem_done: the 0x10 word is dropped.
        expect_req(32'h10);
        redir_alu_valid = 1'b1; redir_alu_dest = 32'h10;
        tick();
        redir_alu_valid = 1'b0;
        wait_flag("req_10");
        redir_br_valid = 1'b1; redir_br_dest = 32'h100;
        ctrl_addr = 32'h100;
        expect_req(32'h100);
        tick();
        redir_br_valid = 1'b0;
        repeat (10) tick();
        chk("drain_head_pc", dec_pc, 32'h100);
        chk("drain_head_inst", dec_inst, 32'h6F);
        chk("drain_req_left", exp_req.size(), 0);

        // alu + br redirect together with mem_done: alu wins, no DRAIN.
        ctrl_addr = 32'h204;
        expect_req(32'h1FC);
        redir_dec_valid = 1'b1; redir_dec_dest = 32'h1FC;
        tick();
        redir_dec_valid = 1'b0;
        wait_flag("req_1fc");
        @(negedge clk);
        redir_alu_valid = 1'b1; redir_alu_dest = 32'h200;
        redir_br_valid  = 1'b1; redir_br_dest  = 32'h300;
        dec_ready = 1'b1;
        expect_req(32'h200); expect_req(32'h204);
        expect_dec(32'h200); expect_dec(32'h204);
        tick();
        redir_alu_valid = 1'b0; redir_br_valid = 1'b0;
        @(negedge clk);
        chk("prio_flush_valid", dec_valid, 1'b0);
        chk("prio_no_req_yet", mem_rw_flag, 2'b00);
        @(negedge clk);
        chk("prio_req_flag", mem_rw_flag, 2'b01);
        chk("prio_req_addr", mem_addr, 32'h200);
        repeat (10) tick();
        chk("prio_dec_left", exp_pc.size(), 0);

        // rdy low for 5 cycles while the read completes.
        ctrl_addr = 32'h304;
        expect_req(32'h300); expect_req(32'h304);
        expect_dec(32'h300); expect_dec(32'h304);
        redir_dec_valid = 1'b1; redir_dec_dest = 32'h300;
        tick();
        redir_dec_valid = 1'b0;
        wait_flag("req_300");
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("frozen_flag", mem_rw_flag, 2'b00);
            chk("frozen_addr", mem_addr, 32'h300);
            chk("frozen_valid", dec_valid, 1'b0);
            chk("frozen_pc", dec_pc, 32'h0);
        end
        @(posedge clk); #2;
        rdy = 1'b1;
        repeat (12) tick();

        chk("final_req_left", exp_req.size(), 0);
        chk("final_dec_left", exp_pc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end. It issues word reads to mem_ctrl, buffers returned instructions with their PCs in an IQ_DEPTH-entry queue, and presents them to the Decoder through a valid/ready handshake.
- Redirects from ALU (jump), branch unit and Decoder flush the queue and restart fetch.
- In-flight responses that a redirect makes stale are discarded.
- Control-flow handling is selectable: stall-until-resolved, or fall-through prefetch.

Parameters:
ADDR_W, 32, address/PC width
INST_W, 32, instruction width
IQ_DEPTH, 4, queue entries; power of two, >= 2
STALL_ON_CTRL, 1, 1 = stop fetching after a branch/JAL/JALR until a redirect arrives; 0 = keep fetching PC+4
RESET_PC, 0, first fetch address

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global enable; when low every register holds
mem_rw_flag  out  2  2'b01 = read request pulse; 2'b00 = none
mem_addr  out  ADDR_W  request address
mem_len  out  2  constant 2'b11 (word)
mem_rdata  in  INST_W  read data, valid with mem_done
mem_busy  in  1  mem_ctrl cannot accept a request
mem_done  in  1  read completed this cycle
dec_valid  out  1  queue head valid
dec_pc  out  ADDR_W  head PC
dec_inst  out  INST_W  head instruction
dec_ready  in  1  Decoder accepts head (alu/ls/rob free)
redir_alu_valid / redir_alu_dest  in  1 / ADDR_W  JALR target
redir_br_valid / redir_br_dest  in  1 / ADDR_W  resolved branch target
redir_dec_valid / redir_dec_dest  in  1 / ADDR_W  JAL target from Decoder

Behaviour:
- Reset (rst_n low, async): fetch_pc = RESET_PC; queue empty (rd/wr ptr = 0, count = 0); state = IDLE.
  - Outputs at reset: mem_rw_flag = 0, mem_addr = RESET_PC, dec_valid = 0, dec_pc = 0, dec_inst = 0.
- rdy low: no state change, no pop. Redirect inputs are sampled only when rdy is high.
- Queue:
  - Circular buffer of {pc, inst}; pointers are log2(IQ_DEPTH)+1 bits.
  - dec_valid = (count != 0). dec_pc/dec_inst are taken combinationally from the head.
  - Pop on dec_valid & dec_ready. Push and pop in the same cycle leave count unchanged.
  - Issue requires count + outstanding < IQ_DEPTH, which guarantees a slot for every response.
- States:
  - IDLE: if !mem_busy and a slot is free, pulse mem_rw_flag = 01 for one cycle, mem_addr = fetch_pc, req_pc <= fetch_pc, fetch_pc += 4, go WAIT. Otherwise stay in IDLE.
  - WAIT: on mem_done, push {req_pc, mem_rdata}.
    - If STALL_ON_CTRL and the opcode is classBranch/JAL/JALR, go HOLD.
    - Else, if !mem_busy and a slot is free after the push, issue the next request in the same cycle (back-to-back) and stay in WAIT.
    - Else go IDLE.
  - HOLD: no requests; wait for a redirect.
  - DRAIN: a redirect arrived with a request outstanding. Wait for mem_done, drop the data, go IDLE.
- Redirect (any valid; priority alu > br > dec):
  - Flush the queue: count = 0, ptrs = 0. Flush beats a same-cycle pop and a same-cycle push.
  - fetch_pc <= dest.
  - Next state: if in WAIT and !mem_done, go DRAIN; otherwise go IDLE.
  - A redirect in DRAIN updates fetch_pc and stays in DRAIN.
  - No request is issued in the redirect cycle.
- Latency: mem_done at edge N gives dec_valid high after edge N; from redirect to the first new request is at least 1 cycle.
- PC arithmetic wraps modulo 2^ADDR_W.
- STALL_ON_CTRL = 0: control instructions are enqueued and fetch continues. Redirects alone correct the path, because all wrong-path entries are flushed.

Decomposition:
- Shared defines file: opcode class constants and ranges (classOpRange, classBranch, classJAL, classJALR) and the mem_ctrl rw_flag encodings. No new typedefs.
- One natural sub-module: fetch_iq, the parametrised circular FIFO with push/pop/flush, count and a head read port. The FSM, PC logic and redirect arbitration stay in fetch_queue.

Test Plan:
- Reset with RESET_PC = 0, memory returning mem_done 2 cycles after each request, dec_ready = 1 -> requests to 0, 4, 8, ... and Decoder sees PCs in order with matching instructions; dec_valid first rises 1 cycle after the first mem_done.
- dec_ready = 0 with IQ_DEPTH = 4 -> exactly 4 requests issued, then mem_rw_flag stays 0. Raising dec_ready for 1 cycle -> one pop, then exactly one new request.
- STALL_ON_CTRL = 1, a JAL fetched at 0x8 -> no request after 0x8. redir_dec_valid with dest 0x40 -> next request is at 0x40, and the queue still delivers 0x8 only if it was popped before the redirect.
- Request outstanding to 0x10, redir_br_valid with dest 0x100 the cycle before mem_done -> data for 0x10 is not enqueued; next request is 0x100.
- Same cycle: redir_alu = 0x200, redir_br = 0x300, mem_done, dec_ready -> queue empty, no DRAIN, next request is 0x200.
- rdy held low for 5 cycles mid-WAIT, with mem_done pulsed while rdy is low -> no state, pointer or output change. The mem_ctrl bench model holds mem_done until rdy is high.
